// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the IF stage of the RV32I pipeline.
//   if_state_t  : fetch FSM states (fetching, holding a fetched word, killing a stale read)
//   NopInstr    : addi x0,x0,0, inserted into IF/ID when no valid instruction is available
//   ResetVector : first fetch address after reset
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StKill  = 2'd2
  } if_state_t;

  localparam logic [31:0] NopInstr    = 32'h0000_0013;
  localparam logic [31:0] ResetVector = 32'h0000_0060;

endpackage

// File: rtl/instruction_fetch_pc_select.sv
// Combinational PC selection for the IF stage.
//   br_miss, br_target : EX mispredict and its correct PC (highest priority)
//   pred_addr          : decode-stage predicted target
//   redir              : a redirect is taking effect this cycle
//   fpc, tgt_q         : current fetch PC and the target latched while killing a read
//   tgt                : redirect target for this cycle
//   kill_tgt           : where to resume once a killed read returns
//   fpc_inc            : sequential next PC (wraps modulo 2^32)
module instruction_fetch_pc_select (
  input  logic        br_miss,
  input  logic [31:0] br_target,
  input  logic [31:0] pred_addr,
  input  logic        redir,
  input  logic [31:0] fpc,
  input  logic [31:0] tgt_q,
  output logic [31:0] tgt,
  output logic [31:0] kill_tgt,
  output logic [31:0] fpc_inc
);

  always_comb begin
    tgt      = br_miss ? br_target : pred_addr;
    // A redirect arriving in the same cycle as the killed response wins over the latched one.
    kill_tgt = redir ? tgt : tgt_q;
    fpc_inc  = fpc + 32'd4;
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, issues I-cache reads (one outstanding at most) and fills the IF/ID register.
// Redirects come from EX (br_miss) or from the decode-stage predictor (pred/pred_addr); a read
// made obsolete by a redirect is drained and its data discarded.
// Ports:
//   clk, rst (sync, active-low)
//   icache_read/icache_address out, icache_resp/icache_rdata in
//   MA_stall, bubble         : backend stall / decode hazard
//   br_miss, br_target       : EX mispredict redirect
//   pred, pred_addr          : decode-stage predicted-taken redirect
//   PC, data_                : IF/ID register to decode
//   IF_stall                 : no valid fetched instruction this cycle
//   false_NOP                : IF/ID holds an inserted NOP
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = ResetVector,
  parameter logic [31:0] NOP_INSTR    = NopInstr
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic        icache_resp,
  input  logic [31:0] icache_rdata,
  input  logic        MA_stall,
  input  logic        bubble,
  input  logic        br_miss,
  input  logic [31:0] br_target,
  input  logic        pred,
  input  logic [31:0] pred_addr,
  output logic [31:0] PC,
  output logic [31:0] data_,
  output logic        IF_stall,
  output logic        false_NOP
);

  if_state_t   state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] data_q, data_d;
  logic        fnop_q, fnop_d;

  logic        adv, redir, avail;
  logic [31:0] tgt, kill_tgt, fpc_inc;
  logic [31:0] deliver_pc, deliver_data;

  // A mispredict overrides a decode hazard; the predictor only acts when ID is not bubbling.
  assign adv   = !MA_stall && (!bubble || br_miss);
  assign redir = !MA_stall && (br_miss || (pred && !bubble));
  assign avail = ((state_q == StFetch) && icache_resp) || (state_q == StHold);

  instruction_fetch_pc_select u_pc_select (
    .br_miss   (br_miss),
    .br_target (br_target),
    .pred_addr (pred_addr),
    .redir     (redir),
    .fpc       (fpc_q),
    .tgt_q     (tgt_q),
    .tgt       (tgt),
    .kill_tgt  (kill_tgt),
    .fpc_inc   (fpc_inc)
  );

  always_comb begin
    deliver_pc   = (state_q == StHold) ? hold_pc_q : fpc_q;
    deliver_data = (state_q == StHold) ? hold_data_q : icache_rdata;
  end

  // Fetch FSM and fetch PC.
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    tgt_d       = tgt_q;
    hold_pc_d   = hold_pc_q;
    hold_data_d = hold_data_q;
    unique case (state_q)
      StFetch: begin
        if (icache_resp) begin
          if (redir) begin
            fpc_d = tgt;
          end else if (adv) begin
            fpc_d = fpc_inc;
          end else begin
            hold_pc_d   = fpc_q;
            hold_data_d = icache_rdata;
            state_d     = StHold;
          end
        end else if (redir) begin
          // Read still in flight: address must stay put until it returns.
          tgt_d   = tgt;
          state_d = StKill;
        end
      end
      StHold: begin
        if (redir) begin
          fpc_d       = tgt;
          hold_pc_d   = '0;
          hold_data_d = '0;
          state_d     = StFetch;
        end else if (adv) begin
          fpc_d   = fpc_inc;
          state_d = StFetch;
        end
      end
      StKill: begin
        if (redir) tgt_d = tgt;
        if (icache_resp) begin
          fpc_d   = kill_tgt;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // IF/ID register.
  always_comb begin
    pc_d   = pc_q;
    data_d = data_q;
    fnop_d = fnop_q;
    if (redir) begin
      pc_d   = '0;
      data_d = NOP_INSTR;
      fnop_d = 1'b1;
    end else if (adv) begin
      if (avail) begin
        pc_d   = deliver_pc;
        data_d = deliver_data;
        fnop_d = 1'b0;
      end else begin
        pc_d   = '0;
        data_d = NOP_INSTR;
        fnop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StFetch;
      fpc_q       <= RESET_VECTOR;
      tgt_q       <= '0;
      hold_pc_q   <= '0;
      hold_data_q <= '0;
      pc_q        <= '0;
      data_q      <= NOP_INSTR;
      fnop_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      tgt_q       <= tgt_d;
      hold_pc_q   <= hold_pc_d;
      hold_data_q <= hold_data_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      fnop_q      <= fnop_d;
    end
  end

  assign icache_read    = rst && (state_q != StHold);
  assign icache_address = fpc_q;
  assign IF_stall       = !avail;
  assign PC             = pc_q;
  assign data_          = data_q;
  assign false_NOP      = fnop_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_read;
  logic [31:0] icache_address;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  logic        MA_stall, bubble, br_miss, pred;
  logic [31:0] br_target, pred_addr;
  logic [31:0] PC, data_;
  logic        IF_stall, false_NOP;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .MA_stall       (MA_stall),
    .bubble         (bubble),
    .br_miss        (br_miss),
    .br_target      (br_target),
    .pred           (pred),
    .pred_addr      (pred_addr),
    .PC             (PC),
    .data_          (data_),
    .IF_stall       (IF_stall),
    .false_NOP      (false_NOP)
  );

  typedef struct {
    logic        rst, resp;
    logic [31:0] rdata;
    logic        ma, bub, brm;
    logic [31:0] brt;
    logic        pr;
    logic [31:0] pa;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_pc, e_data;
    logic        e_fnop;
  } vec_t;

  typedef struct {
    logic [31:0] pc, data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] NOP = 32'h13;

  function automatic vec_t mk(input logic r, input logic rs, input logic [31:0] rd,
                              input logic ma, input logic bub, input logic brm,
                              input logic [31:0] brt, input logic pr, input logic [31:0] pa,
                              input logic erd, input logic [31:0] ead, input logic est,
                              input logic [31:0] epc, input logic [31:0] edt, input logic efn);
    vec_t v;
    v.rst = r; v.resp = rs; v.rdata = rd; v.ma = ma; v.bub = bub; v.brm = brm;
    v.brt = brt; v.pr = pr; v.pa = pa; v.e_read = erd; v.e_addr = ead; v.e_stall = est;
    v.e_pc = epc; v.e_data = edt; v.e_fnop = efn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rs, input logic [31:0] rd, input logic ma,
                       input logic bub, input logic brm, input logic [31:0] brt,
                       input logic pr, input logic [31:0] pa);
    rst = r; icache_resp = rs; icache_rdata = rd; MA_stall = ma; bubble = bub;
    br_miss = brm; br_target = brt; pred = pr; pred_addr = pa;
  endtask

  initial begin
    // rst resp rdata  ma bub brm brt  pr pa | read addr stall | PC data fnop
    vecs.push_back(mk(0,0,0,     0,0,0,0,0,0,     0,32'h60,1, 0,NOP,1));
    // sequential fetch from reset vector
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     1,32'h60,1, 0,NOP,1));
    vecs.push_back(mk(1,1,32'hA0,0,0,0,0,0,0,     1,32'h60,0, 32'h60,32'hA0,0));
    // 0x64 returns under MA_stall: hold, read drops, IF/ID frozen
    vecs.push_back(mk(1,1,32'hA1,1,0,0,0,0,0,     1,32'h64,0, 32'h60,32'hA0,0));
    vecs.push_back(mk(1,0,0,     1,0,0,0,0,0,     0,32'h64,0, 32'h60,32'hA0,0));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     0,32'h64,0, 32'h64,32'hA1,0));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     1,32'h68,1, 0,NOP,1));
    vecs.push_back(mk(1,1,32'hA2,0,0,0,0,0,0,     1,32'h68,0, 32'h68,32'hA2,0));
    vecs.push_back(mk(1,1,32'hA3,0,0,0,0,0,0,     1,32'h6C,0, 32'h6C,32'hA3,0));
    // br_miss while read to 0x70 is outstanding: address held, data discarded
    vecs.push_back(mk(1,0,0,     0,0,1,32'h200,0,0, 1,32'h70,1, 0,NOP,1));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     1,32'h70,1, 0,NOP,1));
    vecs.push_back(mk(1,1,32'hDEAD,0,0,0,0,0,0,   1,32'h70,1, 0,NOP,1));
    vecs.push_back(mk(1,1,32'hB0,0,0,0,0,0,0,     1,32'h200,0, 32'h200,32'hB0,0));
    // redirect with response in the same cycle, then walk to ID=0x100
    vecs.push_back(mk(1,1,32'hB1,0,0,1,32'hFC,0,0, 1,32'h204,0, 0,NOP,1));
    vecs.push_back(mk(1,1,32'hC0,0,0,0,0,0,0,     1,32'hFC,0, 32'hFC,32'hC0,0));
    vecs.push_back(mk(1,1,32'hC1,0,0,0,0,0,0,     1,32'h100,0, 32'h100,32'hC1,0));
    // predicted taken for ID 0x100: fetched 0x104 squashed
    vecs.push_back(mk(1,1,32'hC2,0,0,0,0,1,32'h180, 1,32'h104,0, 0,NOP,1));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     1,32'h180,1, 0,NOP,1));
    // br_miss beats pred
    vecs.push_back(mk(1,1,32'hC3,0,0,1,32'h300,1,32'h180, 1,32'h180,0, 0,NOP,1));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     1,32'h300,1, 0,NOP,1));
    // MA_stall suppresses redirects
    vecs.push_back(mk(1,0,0,     1,0,1,32'h400,1,32'h500, 1,32'h300,1, 0,NOP,1));
    vecs.push_back(mk(1,1,32'hD0,1,0,1,32'h400,0,0, 1,32'h300,0, 0,NOP,1));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     0,32'h300,0, 32'h300,32'hD0,0));
    // bubble holds IF/ID and blocks pred
    vecs.push_back(mk(1,1,32'hD1,0,1,0,0,0,0,     1,32'h304,0, 32'h300,32'hD0,0));
    vecs.push_back(mk(1,0,0,     0,1,0,0,1,32'h700, 0,32'h304,0, 32'h300,32'hD0,0));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     0,32'h304,0, 32'h304,32'hD1,0));
    // reset during KILL with the stale response arriving in the reset cycle
    vecs.push_back(mk(1,0,0,     0,0,1,32'h800,0,0, 1,32'h308,1, 0,NOP,1));
    vecs.push_back(mk(0,1,32'hEEEE,0,0,0,0,0,0,   0,32'h308,1, 0,NOP,1));
    vecs.push_back(mk(1,0,0,     0,0,0,0,0,0,     1,32'h60,1, 0,NOP,1));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].resp, vecs[i].rdata, vecs[i].ma, vecs[i].bub,
            vecs[i].brm, vecs[i].brt, vecs[i].pr, vecs[i].pa);
      #1;
      chk($sformatf("v%0d read", i),  {31'd0, icache_read}, {31'd0, vecs[i].e_read});
      chk($sformatf("v%0d addr", i),  icache_address, vecs[i].e_addr);
      chk($sformatf("v%0d stall", i), {31'd0, IF_stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d PC", i),    PC, vecs[i].e_pc);
      chk($sformatf("v%0d data", i),  data_, vecs[i].e_data);
      chk($sformatf("v%0d fnop", i),  {31'd0, false_NOP}, {31'd0, vecs[i].e_fnop});
    end

    // Streaming across the 2^32 wrap with random response timing, checked by scoreboard.
    begin
      logic [31:0] exp_addr;
      logic        rs;
      logic [31:0] rd;
      sb_t         e;
      @(negedge clk);
      drive(1, 1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
      @(posedge clk);
      exp_addr = 32'hFFFF_FFF8;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        rs = (k < 4) ? 1'b1 : 1'($urandom_range(0, 1));
        rd = {exp_addr[15:0] ^ 16'hA5A5, exp_addr[15:0]};
        drive(1, rs, rd, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sb addr", icache_address, exp_addr);
        if (rs) begin
          e.pc = exp_addr;
          e.data = rd;
          sbq.push_back(e);
          exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        chk("sb fnop", {31'd0, false_NOP}, {31'd0, !rs});
        if (false_NOP === 1'b0) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb underflow: delivered PC %h with nothing expected", PC);
          end else begin
            e = sbq.pop_front();
            chk("sb PC", PC, e.pc);
            chk("sb data", data_, e.data);
          end
        end
      end
      chk("sb drain", sbq.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
